// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text path (pager and lcd driver).
// Latency: n/a (package only).
// Backpressure: n/a.
package lcd_pkg;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam int         LCD_COLS   = 16;

  // One full LCD row of ASCII, first character in the MSB byte.
  typedef logic [8*LCD_COLS-1:0] line_t;

  // Paging mode: buttons only, or buttons plus timed auto-scroll.
  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

endpackage

// File: rtl/btn_edge.sv
// Turns a debounced button level into a one-cycle press pulse on its rising edge.
// Latency: combinational pulse in the cycle the level first reads high.
// Backpressure: none; a press that is not consumed is lost.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic prev_q;

  // Previous level; resets high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= level;
  end

  assign press = level & ~prev_q;

endmodule

// File: rtl/lcd_pager.sv
// Text pager: line buffer with a two-line window stepped by buttons or an auto-scroll timer.
// Latency: press/write at cycle n -> top_idx at n+1, rows and updated pulse at n+2.
// Backpressure: none; writes and presses are always accepted (out-of-range writes dropped).
module lcd_pager
  import lcd_pkg::*;
#(
  parameter  int NUM_LINES   = 4,
  parameter  int LINE_CHARS  = LCD_COLS,
  parameter  int AUTO_PERIOD = 100_000_000,
  localparam int IW          = $clog2(NUM_LINES),
  localparam int LW          = 8 * LINE_CHARS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_next,
  input  logic          btn_prev,
  input  logic          btn_mode,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [LW-1:0] wr_data,
  output logic [LW-1:0] row_A,
  output logic [LW-1:0] row_B,
  output logic [IW-1:0] top_idx,
  output logic          auto_on,
  output logic          updated
);

  localparam int            TW   = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TERM = TW'(AUTO_PERIOD - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_LINES - 1);
  localparam logic [IW:0]   NL_W = (IW + 1)'(NUM_LINES);

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [IW-1:0] wrap_dec(input logic [IW-1:0] i);
    return (i == '0) ? LAST : i - 1'b1;
  endfunction

  logic next_p, prev_p, mode_p, any_p;

  btn_edge u_next (.clk(clk), .rst(rst), .level(btn_next), .press(next_p));
  btn_edge u_prev (.clk(clk), .rst(rst), .level(btn_prev), .press(prev_p));
  btn_edge u_mode (.clk(clk), .rst(rst), .level(btn_mode), .press(mode_p));

  assign any_p = next_p | prev_p | mode_p;

  mode_t         state_q, state_d;
  logic [TW-1:0] timer_q;
  logic          timer_clr, tick;
  logic [IW-1:0] top_q, top_d;
  logic [LW-1:0] line_buf [NUM_LINES];
  logic          wr_ok, wr_hit, wr_diff, chg, pend_q;

  // Mode register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= MANUAL;
    else      state_q <= state_d;
  end

  // Mode transitions and auto tick; any press in AUTO restarts the period and drops a tick.
  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    tick      = 1'b0;
    case (state_q)
      MANUAL: begin
        timer_clr = 1'b1;
        if (mode_p) state_d = AUTO;
      end
      AUTO: begin
        if (mode_p) state_d = MANUAL;
        if (any_p) timer_clr = 1'b1;
        else if (timer_q == TERM) tick = 1'b1;
      end
      default: state_d = MANUAL;
    endcase
  end

  // Auto-scroll period counter, wrapping on the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   timer_q <= '0;
    else if (timer_clr || tick) timer_q <= '0;
    else                        timer_q <= timer_q + 1'b1;
  end

  // Next window position and whether the displayed rows will change.
  always_comb begin
    top_d = top_q;
    if ((next_p && !prev_p) || tick) top_d = wrap_inc(top_q);
    else if (prev_p && !next_p)      top_d = wrap_dec(top_q);
    wr_ok   = wr_en && ({1'b0, wr_addr} < NL_W);
    wr_diff = wr_data != line_buf[wr_addr];
    wr_hit  = (wr_addr == top_d) || (wr_addr == wrap_inc(top_d));
    chg     = (top_d != top_q) || (wr_ok && wr_diff && wr_hit);
  end

  // Window position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) top_q <= '0;
    else      top_q <= top_d;
  end

  // Line buffer, space-filled on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LINES; i++) line_buf[i] <= {LINE_CHARS{CHAR_SPACE}};
    end else if (wr_ok) begin
      line_buf[wr_addr] <= wr_data;
    end
  end

  // Registered rows; updated is delayed one cycle so it lines up with the new rows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_A   <= {LINE_CHARS{CHAR_SPACE}};
      row_B   <= {LINE_CHARS{CHAR_SPACE}};
      pend_q  <= 1'b0;
      updated <= 1'b0;
    end else begin
      row_A   <= line_buf[top_q];
      row_B   <= line_buf[wrap_inc(top_q)];
      pend_q  <= chg;
      updated <= pend_q;
    end
  end

  assign top_idx = top_q;
  assign auto_on = (state_q == AUTO);

endmodule

// File: tb/tb_lcd_pager.sv
// Bench for lcd_pager: a 4-line and a 3-line instance share stimulus; a behavioural
// model predicts every output each cycle, and directed literal checks pin the model.
// Clock period 10 ns, AUTO_PERIOD 10.
module tb_lcd_pager;
  import lcd_pkg::*;

  localparam int P = 10;
  localparam line_t SPACES = {16{8'h20}};
  localparam line_t L0 = {"LINE0", {11{8'h20}}};
  localparam line_t L1 = {"LINE1", {11{8'h20}}};
  localparam line_t L2 = {"LINE2", {11{8'h20}}};
  localparam line_t L3 = {"LINE3", {11{8'h20}}};
  localparam line_t HELLO = {"HELLO", {11{8'h20}}};
  localparam line_t ZERO = {"ZERO", {12{8'h20}}};
  localparam line_t XXXX = {"XXXX", {12{8'h20}}};
  localparam line_t WS = {"WS", {14{8'h20}}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_next, btn_prev, btn_mode, wr_en;
  logic [1:0] wr_addr;
  line_t wr_data;
  line_t row_a4, row_b4, row_a3, row_b3;
  logic [1:0] top4, top3;
  logic auto4, auto3, upd4, upd3;

  always #5 clk = ~clk;

  lcd_pager #(.NUM_LINES(4), .LINE_CHARS(16), .AUTO_PERIOD(P)) dut4 (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev), .btn_mode(btn_mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .row_A(row_a4), .row_B(row_b4),
    .top_idx(top4), .auto_on(auto4), .updated(upd4));

  lcd_pager #(.NUM_LINES(3), .LINE_CHARS(16), .AUTO_PERIOD(P)) dut3 (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev), .btn_mode(btn_mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .row_A(row_a3), .row_B(row_b3),
    .top_idx(top3), .auto_on(auto3), .updated(upd3));

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int    nl [2] = '{4, 3};
  line_t m_lines [2][4];
  int    m_top [2];
  line_t e_ra [2];
  line_t e_rb [2];
  logic  e_upd [2];
  logic  pend [2];
  logic  m_auto;
  int    m_timer;
  logic  pv_n, pv_p, pv_m;

  task automatic model_step();
    logic pn, pp, pm, tick, ok;
    int d, nt, a;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_top[k] = 0; pend[k] = 1'b0; e_upd[k] = 1'b0;
        e_ra[k] = SPACES; e_rb[k] = SPACES;
        for (int j = 0; j < 4; j++) m_lines[k][j] = SPACES;
      end
      m_auto = 1'b0; m_timer = 0;
      pv_n = 1'b1; pv_p = 1'b1; pv_m = 1'b1;
    end else begin
      pn = btn_next && !pv_n;
      pp = btn_prev && !pv_p;
      pm = btn_mode && !pv_m;
      pv_n = btn_next; pv_p = btn_prev; pv_m = btn_mode;
      tick = m_auto && (m_timer == P - 1) && !(pn || pp || pm);
      if (m_auto && !(pn || pp || pm)) m_timer = (m_timer == P - 1) ? 0 : m_timer + 1;
      else m_timer = 0;
      if (pm) m_auto = !m_auto;
      d = 0;
      if (pn && !pp) d = 1;
      else if (pp && !pn) d = -1;
      else if (tick) d = 1;
      a = int'(wr_addr);
      for (int k = 0; k < 2; k++) begin
        e_ra[k] = m_lines[k][m_top[k]];
        e_rb[k] = m_lines[k][(m_top[k] + 1) % nl[k]];
        e_upd[k] = pend[k];
        nt = (m_top[k] + d + nl[k]) % nl[k];
        ok = wr_en && (a < nl[k]);
        pend[k] = (nt != m_top[k]) ||
                  (ok && (m_lines[k][a] != wr_data) && (a == nt || a == (nt + 1) % nl[k]));
        if (ok) m_lines[k][a] = wr_data;
        m_top[k] = nt;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("top4", 128'(top4), 128'(m_top[0]));
        chk("rowA4", row_a4, e_ra[0]);
        chk("rowB4", row_b4, e_rb[0]);
        chk("upd4", 128'(upd4), 128'(e_upd[0]));
        chk("auto4", 128'(auto4), 128'(m_auto));
        chk("top3", 128'(top3), 128'(m_top[1]));
        chk("rowA3", row_a3, e_ra[1]);
        chk("rowB3", row_b3, e_rb[1]);
        chk("upd3", 128'(upd3), 128'(e_upd[1]));
        chk("auto3", 128'(auto3), 128'(m_auto));
        if (upd4) upd_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 next, 1 prev, 2 mode, 3 next+prev
  task automatic press(input int which);
    @(negedge clk);
    btn_next = (which == 0 || which == 3);
    btn_prev = (which == 1 || which == 3);
    btn_mode = (which == 2);
    @(negedge clk);
    btn_next = 1'b0; btn_prev = 1'b0; btn_mode = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input line_t d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int u;
    int seq [4] = '{1, 2, 3, 0};
    int waited;
    btn_next = 1'b1; btn_prev = 1'b0; btn_mode = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = SPACES;

    // Reset with next held through release.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(3);
    chk("rst_top", 128'(top4), 128'(0));
    chk("rst_rowA", row_a4, SPACES);
    chk("rst_rowB", row_b4, SPACES);
    chk("rst_upd", 128'(upd4), 128'(0));
    chk("rst_auto", 128'(auto4), 128'(0));
    btn_next = 1'b0;

    // Load lines and page forward.
    wr(2'd0, L0); wr(2'd1, L1); wr(2'd2, L2); wr(2'd3, L3);
    idle(3);
    u = upd_cnt;
    for (int k = 0; k < 4; k++) begin
      press(0);
      idle(3);
      chk("next_seq", 128'(top4), 128'(seq[k]));
      chk("upd_per_press", 128'(upd_cnt - u), 128'(1));
      u = upd_cnt;
      if (k == 2) begin
        chk("top3_rowA", row_a4, L3);
        chk("top3_rowB", row_b4, L0);
      end
    end

    // Prev wraps 0 -> 3.
    press(1); idle(3);
    chk("prev_wrap_top", 128'(top4), 128'(3));
    chk("prev_wrap_rowB", row_b4, L0);
    press(0); idle(3);
    chk("back_to_0", 128'(top4), 128'(0));

    // Simultaneous next+prev.
    u = upd_cnt;
    press(3); idle(3);
    chk("both_top", 128'(top4), 128'(0));
    chk("both_upd", 128'(upd_cnt - u), 128'(0));

    // Writes against the window at top=1.
    press(0); idle(3);
    chk("top_1", 128'(top4), 128'(1));
    wr(2'd2, HELLO);
    chk("wr_rowB_n1", row_b4, L2);
    @(negedge clk);
    chk("wr_rowB_n2", row_b4, HELLO);
    chk("wr_upd_n2", 128'(upd4), 128'(1));
    idle(2);
    u = upd_cnt;
    wr(2'd0, ZERO); idle(3);
    chk("wr_hidden_upd", 128'(upd_cnt - u), 128'(0));
    wr(2'd3, XXXX); idle(3);
    chk("wr_addr3_upd", 128'(upd_cnt - u), 128'(0));
    wr(2'd2, HELLO); idle(3);
    chk("wr_same_upd", 128'(upd_cnt - u), 128'(0));

    // Write and step in the same cycle.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = WS; btn_next = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; btn_next = 1'b0;
    idle(2);
    chk("wrstep_top", 128'(top4), 128'(2));
    chk("wrstep_rowA", row_a4, WS);

    // Auto mode: steps every P cycles.
    press(2);
    chk("auto_on", 128'(auto4), 128'(1));
    idle(34);
    chk("auto_3steps", 128'(top4), 128'(1));
    waited = 0;
    while (top4 == 2'd1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("auto_4th_step", 128'(top4), 128'(2));
    // Prev on the tick cycle: tick dropped, single backward step, timer restarts.
    idle(8);
    press(1);
    chk("prev_on_tick", 128'(top4), 128'(1));
    idle(9);
    chk("restart_hold", 128'(top4), 128'(1));
    idle(1);
    chk("restart_step", 128'(top4), 128'(2));
    // Next mid-period restarts the timer.
    idle(4);
    press(0);
    chk("mid_next", 128'(top4), 128'(3));
    idle(9);
    chk("mid_hold", 128'(top4), 128'(3));
    idle(1);
    chk("mid_step", 128'(top4), 128'(0));

    // Back to manual: no further motion.
    press(2);
    chk("auto_off", 128'(auto4), 128'(0));
    idle(50);
    chk("manual_still", 128'(top4), 128'(0));

    // Asynchronous reset mid-operation.
    press(2); press(1); idle(2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_top", 128'(top4), 128'(0));
    chk("arst_auto", 128'(auto4), 128'(0));
    chk("arst_upd", 128'(upd4), 128'(0));
    chk("arst_rowA", row_a4, SPACES);
    chk("arst_rowB3", row_b3, SPACES);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Three-line wrap on the second instance.
    wr(2'd2, L1); idle(2);
    press(1); idle(3);
    chk("n3_prev_top", 128'(top3), 128'(2));
    chk("n3_prev_rowA", row_a3, L1);
    chk("n3_prev_rowB", row_b3, SPACES);
    press(0); idle(3);
    chk("n3_next_top", 128'(top3), 128'(0));
    press(0); press(0); press(0); idle(3);
    chk("n3_loop_top", 128'(top3), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
